// File: rtl/fta_bus_pkg.sv
// Purpose: FTA 128-bit command bus payload types shared by bus masters, arbiters and slaves.
package fta_bus_pkg;

    localparam int unsigned FTA_ADR_W = 32;
    localparam int unsigned FTA_DAT_W = 128;
    localparam int unsigned FTA_SEL_W = FTA_DAT_W / 8;
    localparam int unsigned FTA_TID_W = 8;

    typedef struct packed {
        logic                 cyc;
        logic                 we;
        logic [FTA_SEL_W-1:0] sel;
        logic [FTA_TID_W-1:0] tid;
        logic [FTA_ADR_W-1:0] adr;
        logic [FTA_DAT_W-1:0] dat;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic                 ack;
        logic                 rty;
        logic                 err;
        logic [FTA_TID_W-1:0] tid;
        logic [FTA_DAT_W-1:0] dat;
    } fta_cmd_response128_t;

endpackage

// File: rtl/rf80386_pkg.sv
// Purpose: rf80386 core-level shared types.
package rf80386_pkg;

    // FTA port arbiter states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } e_fta_arb_state;

endpackage

// File: rtl/rf80386_rr_pick2.sv
// Purpose: combinational two-way round-robin pick with a lock override.
// Ports:
//   req0_i    - master 0 requesting
//   req1_i    - master 1 requesting
//   prefer1_i - round-robin pointer: 1 favours master 1 on a tie
//   lock_i    - locked sequence held by master 1; only master 1 may win
//   valid_o   - a winner exists (combinational)
//   pick_o    - winner index, meaningful when valid_o (combinational)
module rf80386_rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic prefer1_i,
    input  logic lock_i,
    output logic valid_o,
    output logic pick_o
);

    always_comb begin
        valid_o = 1'b0;
        pick_o  = 1'b0;
        if (lock_i) begin
            // Master 0 is held off entirely while master 1 owns a locked RMW.
            valid_o = req1_i;
            pick_o  = 1'b1;
        end else if (req0_i && req1_i) begin
            valid_o = 1'b1;
            pick_o  = prefer1_i;
        end else begin
            valid_o = req0_i | req1_i;
            pick_o  = req1_i;
        end
    end

endmodule

// File: rtl/rf80386_fta_arbiter.sv
// Purpose: shares the single FTA 128-bit master port between the ifetch refill
//   path (m0) and the data/IO path (m1). One transaction at a time, response
//   routed to the owner only, locked RMW support, hung-slave timeout.
// Ports:
//   clk_i, rst_i - clock, synchronous active-high reset
//   m0_req/resp  - ifetch refill request in / response out
//   m1_req/resp  - CPU data/IO request in / response out
//   lock_i       - m1 keeps the bus across consecutive transactions
//   s_req/s_resp - system bus request out / response in
//   owner_o      - last owner (0=m0, 1=m1), updated after each completion
//   tout_o       - one-cycle pulse when a timeout retry is synthesized
module rf80386_fta_arbiter
    import fta_bus_pkg::*;
    import rf80386_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 1023,
    parameter bit          M0_FIRST = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  fta_cmd_request128_t  m0_req,
    output fta_cmd_response128_t m0_resp,
    input  fta_cmd_request128_t  m1_req,
    output fta_cmd_response128_t m1_resp,
    input  logic                 lock_i,
    output fta_cmd_request128_t  s_req,
    input  fta_cmd_response128_t s_resp,
    output logic                 owner_o,
    output logic                 tout_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    e_fta_arb_state       state_q, state_d;
    fta_cmd_request128_t  s_req_q, s_req_d;
    fta_cmd_request128_t  own_req;
    fta_cmd_response128_t resp;
    logic                 owner_q, owner_d;
    logic                 rr_q, rr_d;       // 1: favour m1 on a tie
    logic                 gnt_q, gnt_d;     // master owning the current transfer
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pick_valid, pick;
    logic                 accept, fire;

    rf80386_rr_pick2 u_pick (
        .req0_i    (m0_req.cyc),
        .req1_i    (m1_req.cyc),
        .prefer1_i (rr_q),
        .lock_i    (lock_i & owner_q),
        .valid_o   (pick_valid),
        .pick_o    (pick)
    );

    assign own_req = gnt_q ? m1_req : m0_req;
    // Only a response carrying the outstanding tid belongs to this transfer.
    assign accept  = (s_resp.ack | s_resp.rty) && (s_resp.tid == s_req_q.tid);
    assign fire    = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign s_req   = s_req_q;
    assign owner_o = owner_q;

    // State and bus registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            s_req_q <= '0;
            owner_q <= ~M0_FIRST;
            rr_q    <= ~M0_FIRST;
            gnt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_req_q <= s_req_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, bus request and response routing.
    always_comb begin
        state_d = state_q;
        s_req_d = '0;
        owner_d = owner_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        cnt_d   = '0;
        resp    = '0;
        tout_o  = 1'b0;
        m0_resp = '0;
        m1_resp = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick;
                    s_req_d = pick ? m1_req : m0_req;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    // A real response beats a coincident timeout.
                    resp    = s_resp;
                    state_d = DRAIN;
                end else if (!own_req.cyc) begin
                    state_d = IDLE;
                end else if (fire) begin
                    resp.rty = 1'b1;
                    resp.tid = s_req_q.tid;
                    tout_o   = 1'b1;
                    state_d  = DRAIN;
                end else begin
                    s_req_d = own_req;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                // Hand priority to the other master for the next tie.
                owner_d = gnt_q;
                rr_d    = ~gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (gnt_q) m1_resp = resp;
        else       m0_resp = resp;
    end

endmodule

// File: tb/tb_rf80386_fta_arbiter.sv
// Table-driven bench for rf80386_fta_arbiter with hand-written timeout sequences.
module tb_rf80386_fta_arbiter;
    import fta_bus_pkg::*;

    localparam logic [127:0] D = {2{64'hCAFE_F00D_1234_5678}};

    logic                 clk = 1'b0;
    logic                 rst_i;
    fta_cmd_request128_t  m0_req, m1_req, s_req;
    fta_cmd_response128_t m0_resp, m1_resp, s_resp;
    logic                 lock_i, owner_o, tout_o;

    int nerr = 0;
    int nchk = 0;

    typedef struct {
        bit         rst, m0c, m1c, lock, ack, rty;
        logic [7:0] stid;
        bit         e_scyc;
        logic [7:0] e_stid;
        bit         e_m0a, e_m0r, e_m1a, e_m1r, e_own;
        bit         chk;
    } vec_t;

    vec_t vq[$];

    rf80386_fta_arbiter dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .m0_req  (m0_req),
        .m0_resp (m0_resp),
        .m1_req  (m1_req),
        .m1_resp (m1_resp),
        .lock_i  (lock_i),
        .s_req   (s_req),
        .s_resp  (s_resp),
        .owner_o (owner_o),
        .tout_o  (tout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // fwd: 0 = nothing forwarded, 1 = to m0, 2 = to m1
    function automatic void row(input bit rst, input bit m0c, input bit m1c, input bit lock,
                                input bit ack, input bit rty, input logic [7:0] stid,
                                input bit e_scyc, input logic [7:0] e_stid, input int fwd,
                                input bit e_own);
        vec_t v;
        v.rst = rst; v.m0c = m0c; v.m1c = m1c; v.lock = lock;
        v.ack = ack; v.rty = rty; v.stid = stid;
        v.e_scyc = e_scyc; v.e_stid = e_stid;
        v.e_m0a = (fwd == 1) && ack; v.e_m0r = (fwd == 1) && rty;
        v.e_m1a = (fwd == 2) && ack; v.e_m1r = (fwd == 2) && rty;
        v.e_own = e_own;
        v.chk = !rst;
        vq.push_back(v);
    endfunction

    // One granted transaction: IDLE, 3 XFER cycles with ack on the last, DRAIN.
    function automatic void txn(input bit g, input bit own, input bit m0c, input bit m1c,
                                input bit lock);
        logic [7:0] t;
        t = g ? 8'h21 : 8'h10;
        row(0, m0c, m1c, lock, 0, 0, 8'h00, 0, 8'h00, 0, own);
        row(0, m0c, m1c, lock, 0, 0, 8'h00, 1, t, 0, own);
        row(0, m0c, m1c, lock, 0, 0, 8'h00, 1, t, 0, own);
        row(0, m0c, m1c, lock, 1, 0, t, 1, t, g ? 2 : 1, own);
        row(0, m0c, m1c, lock, 0, 0, 8'h00, 0, 8'h00, 0, own);
    endfunction

    task automatic timeout_seq(input bit ack_at_fire);
        @(negedge clk);
        rst_i = 1'b1; m0_req.cyc = 1'b0; m1_req.cyc = 1'b0; lock_i = 1'b0; s_resp = '0;
        @(negedge clk);
        rst_i = 1'b0; m1_req.cyc = 1'b1;
        for (int i = 1; i <= 1024; i++) begin
            @(negedge clk);
            s_resp = '0;
            if (i == 1023 && ack_at_fire) begin
                s_resp.ack = 1'b1; s_resp.tid = 8'h21; s_resp.dat = D;
            end
            if (i == 1024) m1_req.cyc = 1'b0;
            #1;
            if (i == 1) chk("to_sadr", 64'(s_req.adr), 64'h1000);
            if (i == 1022) chk("to_pre", {61'd0, s_req.cyc, |m1_resp, tout_o}, 64'b100);
            if (i == 1023) begin
                if (ack_at_fire) begin
                    chk("to_ackwin", {61'd0, m1_resp.ack, m1_resp.rty, tout_o}, 64'b100);
                end else begin
                    chk("to_fire", {60'd0, m1_resp.ack, m1_resp.rty, tout_o, |m0_resp}, 64'b0110);
                    chk("to_dat", 64'(m1_resp.dat), 64'h0);
                end
            end
            if (i == 1024) chk("to_post", {61'd0, s_req.cyc, |m1_resp, tout_o}, 64'b000);
        end
    endtask

    initial begin
        logic [16:0] obs, expv;
        rst_i = 1'b1; lock_i = 1'b0; s_resp = '0;
        m0_req = '0; m0_req.sel = 16'hFFFF; m0_req.tid = 8'h10; m0_req.adr = 32'h000F_FFF0;
        m1_req = '0; m1_req.we = 1'b1; m1_req.sel = 16'h000F; m1_req.tid = 8'h21;
        m1_req.adr = 32'h0000_1000; m1_req.dat = 128'h55;

        // m0 alone
        txn(0, 0, 1, 0, 0);
        row(0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        // both requesting from reset: strict alternation, m0 first
        row(1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        for (int k = 0; k < 8; k++)
            txn(k[0], (k == 0) ? 1'b0 : ~k[0], 1, 1, 0);
        // locked RMW: m1 keeps the bus, m0 waits even when alone
        txn(1, 1, 1, 1, 1);
        txn(1, 1, 1, 1, 1);
        row(0, 1, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        row(0, 1, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        txn(0, 1, 1, 0, 0);
        // wrong tid dropped, correct tid two cycles later completes
        row(0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        row(0, 0, 1, 0, 0, 0, 8'h00, 1, 8'h21, 0, 0);
        row(0, 0, 1, 0, 1, 0, 8'h99, 1, 8'h21, 0, 0);
        row(0, 0, 1, 0, 0, 0, 8'h00, 1, 8'h21, 0, 0);
        row(0, 0, 1, 0, 1, 0, 8'h21, 1, 8'h21, 2, 0);
        row(0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        row(0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        // owner aborts before any response: straight back to IDLE, owner unchanged
        row(0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        row(0, 1, 0, 0, 0, 0, 8'h00, 1, 8'h10, 0, 1);
        row(0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h10, 0, 1);
        row(0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        // slave retry forwarded to owner
        row(0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        row(0, 1, 0, 0, 0, 1, 8'h10, 1, 8'h10, 1, 1);
        row(0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        // reset during XFER: late ack ignored
        row(0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        row(0, 1, 0, 0, 0, 0, 8'h00, 1, 8'h10, 0, 0);
        row(1, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        row(0, 0, 0, 0, 1, 0, 8'h10, 0, 8'h00, 0, 0);
        row(0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_sreq", 64'(|s_req), 64'h0);
        chk("rst_m0resp", 64'(|m0_resp), 64'h0);
        chk("rst_m1resp", 64'(|m1_resp), 64'h0);
        chk("rst_owner", 64'(owner_o), 64'h0);
        chk("rst_tout", 64'(tout_o), 64'h0);

        foreach (vq[k]) begin
            @(negedge clk);
            rst_i = vq[k].rst;
            m0_req.cyc = vq[k].m0c;
            m1_req.cyc = vq[k].m1c;
            lock_i = vq[k].lock;
            s_resp = '0;
            s_resp.ack = vq[k].ack;
            s_resp.rty = vq[k].rty;
            s_resp.tid = vq[k].stid;
            s_resp.dat = D;
            #1;
            if (vq[k].chk) begin
                obs  = {s_req.cyc, s_req.tid, m0_resp.ack, m0_resp.rty, |m0_resp,
                        m1_resp.ack, m1_resp.rty, |m1_resp, owner_o, tout_o};
                expv = {vq[k].e_scyc, vq[k].e_stid, vq[k].e_m0a, vq[k].e_m0r,
                        vq[k].e_m0a | vq[k].e_m0r, vq[k].e_m1a, vq[k].e_m1r,
                        vq[k].e_m1a | vq[k].e_m1r, vq[k].e_own, 1'b0};
                chk($sformatf("vec%0d", k), 64'(obs), 64'(expv));
                if (vq[k].e_m0a) chk($sformatf("vec%0d_dat0", k), m0_resp.dat[63:0], D[63:0]);
                if (vq[k].e_m1a) chk($sformatf("vec%0d_dat1", k), m1_resp.dat[63:0], D[63:0]);
            end
        end

        timeout_seq(1'b0);
        timeout_seq(1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
